// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of a UART transmitter; each launch is a one-clk tx_ready pulse, spaced by a frame timer.
// Optional sticky overflow flag (ports ovf_clr/overflow) is enabled with `define UART_TX_FIFO_OVF_EN.
module uart_tx_fifo #(
  parameter int DEPTH      = 16,
  parameter int ADDR_BITS  = 4,
  parameter int FRAME_CLKS = 35200,
  parameter int TIMER_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           wr_data,
  input  logic                 wr_en,
  output logic                 full,
  output logic                 empty,
  output logic [ADDR_BITS:0]   count,
  output logic [7:0]           tx_send,
  output logic                 tx_ready,
`ifdef UART_TX_FIFO_OVF_EN
  input  logic                 ovf_clr,
  output logic                 overflow,
`endif
  output logic                 busy
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [ADDR_BITS:0]    COUNT_FULL = (ADDR_BITS+1)'(DEPTH);
  localparam logic [TIMER_BITS-1:0] TIMER_LAST = TIMER_BITS'(FRAME_CLKS - 1);

  state_t                state, state_nxt;
  logic [7:0]            mem [DEPTH];
  logic [ADDR_BITS-1:0]  wr_ptr, rd_ptr;
  logic [TIMER_BITS-1:0] timer;
  logic                  push, pop;

  assign full  = (count == COUNT_FULL);
  assign empty = (count == '0);
  assign busy  = (state != IDLE) || !empty;
  // full is taken from the pre-edge count, so a same-cycle pop never frees room for a push
  assign push  = wr_en && !full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop       = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: if (timer == TIMER_LAST) state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      timer    <= '0;
      tx_ready <= 1'b0;
      tx_send  <= 8'h00;
    end else begin
      tx_ready <= pop;
      if (push) wr_ptr <= wr_ptr + ADDR_BITS'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + ADDR_BITS'(1);
        tx_send <= mem[rd_ptr];
        timer   <= '0;
      end else if (state == WAIT && timer != TIMER_LAST) begin
        timer <= timer + TIMER_BITS'(1);
      end
      if (push && !pop)      count <= count + (ADDR_BITS+1)'(1);
      else if (pop && !push) count <= count - (ADDR_BITS+1)'(1);
    end
  end

  // Storage carries no reset; the pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

`ifdef UART_TX_FIFO_OVF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                overflow <= 1'b0;
    else if (wr_en && full) overflow <= 1'b1;
    else if (ovf_clr)       overflow <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo (DEPTH=4, FRAME_CLKS=8); overflow checks follow UART_TX_FIFO_OVF_EN.
module tb_uart_tx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full, empty, tx_ready, busy;
  logic [2:0] count;
  logic [7:0] tx_send;
`ifdef UART_TX_FIFO_OVF_EN
  logic       ovf_clr;
  logic       overflow;
`endif

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  int         pulse_q[$];

  uart_tx_fifo #(.DEPTH(4), .ADDR_BITS(2), .FRAME_CLKS(8), .TIMER_BITS(4)) dut (
    .clk(clk),
    .rst(rst),
    .wr_data(wr_data),
    .wr_en(wr_en),
    .full(full),
    .empty(empty),
    .count(count),
    .tx_send(tx_send),
    .tx_ready(tx_ready),
`ifdef UART_TX_FIFO_OVF_EN
    .ovf_clr(ovf_clr),
    .overflow(overflow),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int max);
    int n = 0;
    while (busy && n < max) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_spacing(input int n);
    check("pulse_count", pulse_q.size(), n);
    for (int i = 1; i < pulse_q.size(); i++)
      check("pulse_gap", pulse_q[i] - pulse_q[i-1], 9);
  endtask

  task automatic push_byte(input logic [7:0] b);
    exp_q.push_back(b);
    wr_data = b;
    wr_en   = 1'b1;
  endtask

  // Monitor: every launch pulse is checked against the head of the expected queue
  always @(negedge clk) begin
    if (tx_ready) begin
      pulse_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: got tx_send=%0h, expected no pulse (cycle %0d)", tx_send, cyc);
      end else begin
        check("tx_send_order", tx_send, exp_q.pop_front());
      end
    end
  end

  int push_edge[10] = '{1, 2, 3, 11, 12, 20, 29, 38, 47, 56};

  initial begin
    int cnt_exp;
    int pi;
    logic p, q;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
`endif
    #2;
    check("rst_tx_ready", tx_ready, 0);
    check("rst_tx_send", tx_send, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_busy", busy, 0);
`ifdef UART_TX_FIFO_OVF_EN
    check("rst_overflow", overflow, 0);
`endif
    tick(); tick();
    rst = 1'b0;
    repeat (20) begin
      tick();
      check("idle_busy", busy, 0);
      check("idle_tx_ready", tx_ready, 0);
    end

    // Single byte
    push_byte(8'hA5);
    tick();
    wr_en = 1'b0;
    check("single_count_after_push", count, 1);
    tick();
    check("single_tx_ready", tx_ready, 1);
    check("single_tx_send", tx_send, 8'hA5);
    check("single_count_after_pop", count, 0);
    repeat (7) tick();
    check("single_busy_wait", busy, 1);
    check("single_tx_ready_low", tx_ready, 0);
    tick();
    check("single_busy_drop", busy, 0);
    check("single_tx_send_held", tx_send, 8'hA5);

    // Burst: filler launches first so 01..04 accumulate during its WAIT
    pulse_q.delete();
    push_byte(8'h5A);
    tick();
    wr_en = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
      tick();
    end
    check("burst_count4", count, 4);
    check("burst_full", full, 1);
    wr_data = 8'hFF;
    wr_en   = 1'b1;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b1;
`endif
    tick();
    wr_en = 1'b0;
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
`endif
    check("ovf_count", count, 4);
    check("ovf_full", full, 1);
    tick();
`ifdef UART_TX_FIFO_OVF_EN
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
`endif
    tick();
`ifdef UART_TX_FIFO_OVF_EN
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
`endif
    tick();
    check("burst_count_pre_pop", count, 4);
    tick();
    check("burst_count_post_pop", count, 3);
    check("burst_full_drop", full, 0);
    check("burst_first_ready", tx_ready, 1);
    check("burst_first_byte", tx_send, 8'h01);
    wait_idle(200);
    check("burst_queue_drained", exp_q.size(), 0);
    check_spacing(5);

    // Wrap with pushes on pop edges
    pulse_q.delete();
    cnt_exp = 0;
    pi = 0;
    for (int k = 1; k <= 86; k++) begin
      p = (pi < 10) && (push_edge[pi] == k);
      if (p) begin
        push_byte(8'h10 + 8'(pi));
        pi++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      wr_en = 1'b0;
      q = (k >= 2) && (k <= 83) && ((k - 2) % 9 == 0);
      cnt_exp = cnt_exp + int'(p) - int'(q);
      check("wrap_count", count, cnt_exp);
    end
    wait_idle(50);
    check("wrap_queue_drained", exp_q.size(), 0);
    check_spacing(10);

    // Reset in the middle of WAIT with two bytes still queued
    push_byte(8'h20);
    tick();
    push_byte(8'h21);
    tick();
    push_byte(8'h22);
    tick();
    wr_en = 1'b0;
    tick(); tick(); tick();
    check("midwait_count", count, 2);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("midrst_count", count, 0);
    check("midrst_empty", empty, 1);
    check("midrst_full", full, 0);
    check("midrst_busy", busy, 0);
    check("midrst_tx_ready", tx_ready, 0);
    check("midrst_tx_send", tx_send, 0);
    tick();
    rst = 1'b0;
    tick();
    check("post_rst_busy", busy, 0);
    push_byte(8'h3C);
    tick();
    wr_en = 1'b0;
    check("post_rst_count", count, 1);
    tick();
    check("post_rst_tx_ready", tx_ready, 1);
    check("post_rst_tx_send", tx_send, 8'h3C);
    wait_idle(50);
    check("final_queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
